image_uart_tx: RTL and testbench

//  Streams a stored image out of block RAM over an 8N1 UART line. This is the transmit-side

---
 rtl/image_uart_tx.sv | 164 ++++++++++++++++
 tb/tb_image_uart_tx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_uart_tx.sv
// Streams NUM_BYTES bytes from block RAM, starting at address 0, over an 8N1 UART line.
// Each byte is fetched from RAM, then sent as a start bit, 8 data bits LSB first, and a stop bit.
module image_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned NUM_BYTES    = 3969,
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] byte_cnt
);
    localparam int unsigned TMR_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned WAIT_W = $clog2(READ_LATENCY + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY);
    localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP, DONE} state_t;

    state_t            state, state_n;
    logic [7:0]        shift_reg, shift_reg_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic [TMR_W-1:0]  bit_tmr, bit_tmr_n;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;
    logic              tx_n, busy_n, done_n, rd_en_n;
    logic [ADDR_W-1:0] rd_addr_n, byte_cnt_n;

    // State and output registers; reset forces the line idle-high immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            bit_tmr   <= '0;
            wait_cnt  <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            byte_cnt  <= '0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_reg_n;
            bit_idx   <= bit_idx_n;
            bit_tmr   <= bit_tmr_n;
            wait_cnt  <= wait_cnt_n;
            tx        <= tx_n;
            busy      <= busy_n;
            done      <= done_n;
            rd_en     <= rd_en_n;
            rd_addr   <= rd_addr_n;
            byte_cnt  <= byte_cnt_n;
        end
    end

    // Next-state logic; tx_n is the line level for the cycle after this edge.
    always_comb begin
        state_n     = state;
        shift_reg_n = shift_reg;
        bit_idx_n   = bit_idx;
        bit_tmr_n   = bit_tmr;
        wait_cnt_n  = wait_cnt;
        tx_n        = tx;
        busy_n      = busy;
        done_n      = 1'b0;
        rd_en_n     = rd_en;
        rd_addr_n   = rd_addr;
        byte_cnt_n  = byte_cnt;

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (start) begin
                    rd_addr_n  = '0;
                    rd_en_n    = 1'b1;
                    byte_cnt_n = '0;
                    busy_n     = 1'b1;
                    wait_cnt_n = '0;
                    state_n    = FETCH;
                end
            end
            FETCH: begin
                if (wait_cnt == WAIT_LAST) begin
                    shift_reg_n = rd_data;
                    rd_en_n     = 1'b0;
                    bit_tmr_n   = '0;
                    tx_n        = 1'b0;
                    state_n     = START;
                end else begin
                    wait_cnt_n = wait_cnt + WAIT_W'(1);
                end
            end
            START: begin
                if (bit_tmr == TMR_LAST) begin
                    bit_tmr_n = '0;
                    bit_idx_n = '0;
                    tx_n      = shift_reg[0];
                    state_n   = DATA;
                end else begin
                    bit_tmr_n = bit_tmr + TMR_W'(1);
                end
            end
            DATA: begin
                if (bit_tmr == TMR_LAST) begin
                    bit_tmr_n = '0;
                    if (bit_idx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = shift_reg[bit_idx + 3'd1];
                    end
                end else begin
                    bit_tmr_n = bit_tmr + TMR_W'(1);
                end
            end
            STOP: begin
                if (bit_tmr == TMR_LAST) begin
                    bit_tmr_n  = '0;
                    byte_cnt_n = byte_cnt + ADDR_W'(1);
                    if (byte_cnt == LAST_BYTE) begin
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        rd_addr_n  = rd_addr + ADDR_W'(1);
                        rd_en_n    = 1'b1;
                        wait_cnt_n = '0;
                        state_n    = FETCH;
                    end
                end else begin
                    bit_tmr_n = bit_tmr + TMR_W'(1);
                end
            end
            DONE: begin
                tx_n    = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Abort wins over every transition and never produces a done pulse.
        if (abort && state != IDLE) begin
            state_n   = IDLE;
            tx_n      = 1'b1;
            rd_en_n   = 1'b0;
            busy_n    = 1'b0;
            done_n    = 1'b0;
            bit_tmr_n = '0;
        end
    end
endmodule

// File: tb/tb_image_uart_tx.sv
// Scoreboarded bench for image_uart_tx: expected frames/addresses are queued at start,
// a line monitor decodes tx frames and checks them against the queue.
module tb_image_uart_tx;
    localparam int unsigned CPB   = 4;
    localparam int unsigned NB    = 4;
    localparam int unsigned RL    = 2;
    localparam int unsigned AW    = 12;
    localparam int unsigned FRAME = 10 * CPB;
    localparam int unsigned GAP   = RL + 1;

    typedef struct {
        logic [7:0] data;
        int         gap;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          start1 = 1'b0;
    logic          rd_en, rd_en1, tx, tx1, busy, busy1, done, done1;
    logic [AW-1:0] rd_addr, rd_addr1, byte_cnt, byte_cnt1;
    logic [7:0]    rd_data, rd_data1;
    logic [7:0]    mem [NB];
    logic [7:0]    p1, p2, q1, q2;

    exp_t fq[$];
    int   aq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    image_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .ADDR_W(AW), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .tx(tx), .busy(busy), .done(done), .byte_cnt(byte_cnt)
    );

    image_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(1), .ADDR_W(AW), .READ_LATENCY(RL)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(1'b0),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .tx(tx1), .busy(busy1), .done(done1), .byte_cnt(byte_cnt1)
    );

    always #5 clk = ~clk;

    // Two-stage BRAM models: data visible RL cycles after rd_en.
    always @(posedge clk) begin
        if (rd_en) p1 <= mem[rd_addr[1:0]];
        p2 <= p1;
        if (rd_en1) q1 <= 8'hA0;
        q2 <= q1;
    end
    assign rd_data  = p2;
    assign rd_data1 = q2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line monitor for the main DUT
    logic mon_active = 1'b0;
    int   mon_pos = 0, mon_idx = 0, gap_run = 0, done_cnt = 0;
    logic samp [FRAME];
    logic prev_rd_en = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (rd_en === 1'b1 && prev_rd_en !== 1'b1) begin
            check("addr_q_nonempty", 32'(aq.size() > 0), 1);
            if (aq.size() > 0) check("rd_addr", 32'(rd_addr), 32'(aq.pop_front()));
        end
        prev_rd_en = rd_en;

        if (reset || abort) begin
            if (mon_active) begin
                mon_active = 1'b0;
                mon_idx++;
            end
            gap_run = 0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_pos    = 0;
                samp[0]    = tx;
                cur        = '{8'h00, 0};
                check("frame_q_nonempty", 32'(fq.size() > 0), 1);
                if (fq.size() > 0) begin
                    cur = fq.pop_front();
                    if (cur.gap > 0) check("idle_gap", 32'(gap_run), 32'(cur.gap));
                end
            end else begin
                gap_run++;
            end
        end else begin
            mon_pos++;
            samp[mon_pos] = tx;
            if (mon_pos == FRAME - 1) begin
                int         shape_err;
                logic [7:0] b;
                shape_err = 0;
                for (int i = 0; i < 10; i++)
                    for (int k = 0; k < CPB; k++)
                        if (samp[i*CPB + k] !== samp[i*CPB + CPB/2]) shape_err++;
                for (int i = 0; i < 8; i++) b[i] = samp[(i+1)*CPB + CPB/2];
                check("frame_shape", 32'(shape_err), 0);
                check("start_bit", 32'(samp[CPB/2]), 0);
                check("stop_bit", 32'(samp[9*CPB + CPB/2]), 1);
                check("frame_data", 32'(b), 32'(cur.data));
                mon_active = 1'b0;
                mon_idx++;
                gap_run = 0;
            end
        end
    end

    task automatic push_xfer(input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back('{mem[i], (i == 0) ? 0 : int'(GAP)});
            aq.push_back(i);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(posedge clk); #1;
            if (busy === 1'b0 && !mon_active) found = 1'b1;
        end
        check(tag, 32'(found), 1);
    endtask

    task automatic wait_pos(input int idx, input int pos, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(posedge clk); #1;
            if (mon_active && mon_idx == idx && mon_pos == pos) found = 1'b1;
        end
        check(tag, 32'(found), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx"}, 32'(tx), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_rd_en"}, 32'(rd_en), 0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 0);
        check({tag, "_byte_cnt"}, 32'(byte_cnt), 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int         d0, base, errs, dones;
        logic [7:0] a0;
        bit         found;

        for (int i = 0; i < NB; i++) mem[i] = 8'(8'hA0 + i);
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // 1: basic transfer A0..A3
        d0 = done_cnt;
        push_xfer(NB);
        pulse_start();
        check("t1_busy_after_start", 32'(busy), 1);
        wait_idle("t1_idle");
        check("t1_done_pulses", 32'(done_cnt - d0), 1);
        check("t1_byte_cnt", 32'(byte_cnt), NB);
        check("t1_busy_low", 32'(busy), 0);
        check("t1_frames_left", 32'(fq.size()), 0);

        // 2: data patterns
        mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h55; mem[3] = 8'hAA;
        push_xfer(NB);
        pulse_start();
        wait_idle("t2_idle");
        check("t2_addr_left", 32'(aq.size()), 0);
        check("t2_frames_left", 32'(fq.size()), 0);

        // 3: start during byte 1 is ignored
        for (int i = 0; i < NB; i++) mem[i] = 8'(8'hA0 + i);
        d0   = done_cnt;
        base = mon_idx;
        push_xfer(NB);
        pulse_start();
        wait_pos(base + 1, 5, "t3_reach_byte1");
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle("t3_idle");
        repeat (10) @(posedge clk);
        #1;
        check("t3_done_pulses", 32'(done_cnt - d0), 1);
        check("t3_frames_left", 32'(fq.size()), 0);
        check("t3_busy", 32'(busy), 0);

        // 4: abort during data bit 3 of byte 2
        d0   = done_cnt;
        base = mon_idx;
        push_xfer(3);
        pulse_start();
        wait_pos(base + 2, 4 * CPB, "t4_reach_bit3");
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("t4_tx", 32'(tx), 1);
        check("t4_busy", 32'(busy), 0);
        check("t4_rd_en", 32'(rd_en), 0);
        check("t4_byte_cnt", 32'(byte_cnt), 2);
        repeat (20) @(posedge clk);
        #1;
        check("t4_no_done", 32'(done_cnt - d0), 0);
        check("t4_line_idle", 32'(tx), 1);
        d0 = done_cnt;
        push_xfer(NB);
        pulse_start();
        wait_idle("t4_restart_idle");
        check("t4_restart_done", 32'(done_cnt - d0), 1);
        check("t4_restart_frames", 32'(fq.size()), 0);

        // 5: async reset during the start bit
        base = mon_idx;
        push_xfer(1);
        pulse_start();
        wait_pos(base, 1, "t5_reach_start");
        reset = 1'b1;
        #1 check_reset_vals("t5");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("t5_frames_left", 32'(fq.size()), 0);

        // 6: single-byte image with start held -> back-to-back A0 frames
        a0 = 8'hA0;
        @(posedge clk); #1 start1 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            if (tx1 === 1'b0) found = 1'b1;
        end
        check("t6_first_frame", 32'(found), 1);
        dones = 0;
        for (int per = 0; per < 2; per++) begin
            errs = 0;
            for (int c = 0; c < FRAME + 5; c++) begin
                logic ex;
                if (per != 0 || c != 0) begin
                    @(posedge clk); #1;
                end
                if (c < CPB) ex = 1'b0;
                else if (c < 9 * CPB) ex = a0[(c - CPB) / CPB];
                else ex = 1'b1;
                if (tx1 !== ex) errs++;
                if (done1 !== 1'(c == FRAME)) errs++;
                if (done1 === 1'b1) dones++;
            end
            check("t6_period_wave", 32'(errs), 0);
        end
        check("t6_done_pulses", 32'(dones), 2);
        start1 = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("t6_busy_low", 32'(busy1), 0);
        check("t6_byte_cnt", 32'(byte_cnt1), 1);
        check("t6_rd_addr", 32'(rd_addr1), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
